// File: rtl/prg_mem_sequencer.sv
// Sequences program-memory byte accesses (write / read / burst read) as SETUP-PULSE-HOLD
// prg_clock phases, one response per byte, and controls the target CPU reset line.
module prg_mem_sequencer #(
  parameter int PHASE_CYCLES = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] prg_ma,
  output logic [7:0] prg_wd,
  input  logic [7:0] prg_rd,
  output logic       prg_clock,
  output logic       prg_we,
  output logic       cpu_reset_n
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] OP_WR    = 2'b00;
  localparam logic [1:0] OP_BURST = 2'b10;
  localparam logic [1:0] OP_CPU   = 2'b11;

  localparam logic [3:0] PH_LAST = 4'(PHASE_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic [8:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [7:0] ma_q, ma_d;
  logic [7:0] wd_q, wd_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;
  logic       cpu_rst_n_q, cpu_rst_n_d;
  logic       rdy_en_q;
  logic       phase_last;

  assign phase_last  = (phase_q == PH_LAST);
  assign cmd_ready   = rdy_en_q && (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign prg_ma      = ma_q;
  assign prg_wd      = wd_q;
  assign prg_clock   = (state_q == S_PULSE);
  assign prg_we      = (op_q == OP_WR) &&
                       ((state_q == S_SETUP) || (state_q == S_PULSE) || (state_q == S_HOLD));
  assign cpu_reset_n = cpu_rst_n_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    ma_d        = ma_q;
    wd_d        = wd_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cpu_rst_n_d = cpu_rst_n_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_op == OP_CPU) begin
            cpu_rst_n_d = ~cmd_data[0];
            rsp_data_d  = {7'b0, cmd_data[0]};
            rsp_err_d   = 1'b0;
            state_d     = S_RESP;
          end else if (cpu_rst_n_q) begin
            // Memory is only accessible while the CPU is held in reset.
            rsp_data_d = 8'hFF;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
          end else begin
            op_d    = cmd_op;
            ma_d    = cmd_addr;
            wd_d    = cmd_data;
            cnt_d   = (cmd_op == OP_BURST) ? ({1'b0, cmd_data} + 9'd1) : 9'd1;
            phase_d = 4'd0;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        phase_d = phase_last ? 4'd0 : phase_q + 4'd1;
        if (phase_last) state_d = S_PULSE;
      end
      S_PULSE: begin
        phase_d = phase_last ? 4'd0 : phase_q + 4'd1;
        if (phase_last) state_d = S_HOLD;
      end
      S_HOLD: begin
        phase_d = phase_last ? 4'd0 : phase_q + 4'd1;
        if (phase_last) begin
          rsp_data_d = (op_q == OP_WR) ? wd_q : prg_rd;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (cnt_q > 9'd1) begin
            cnt_d   = cnt_q - 9'd1;
            ma_d    = ma_q + 8'd1;
            phase_d = 4'd0;
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      phase_q     <= 4'd0;
      cnt_q       <= 9'd0;
      op_q        <= 2'b00;
      ma_q        <= 8'h00;
      wd_q        <= 8'h00;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ma_q        <= ma_d;
      wd_q        <= wd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prg_mem_sequencer.sv
// Directed bench for prg_mem_sequencer with PHASE_CYCLES=2 and a read-only memory model.
module tb_prg_mem_sequencer;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [7:0] prg_ma;
  logic [7:0] prg_wd;
  logic [7:0] prg_rd;
  logic       prg_clock;
  logic       prg_we;
  logic       cpu_reset_n;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [256];
  int hi_cyc = 0;
  int we_cyc = 0;
  int pulses = 0;
  logic [7:0] last_ma = 8'h00;
  logic [7:0] last_wd = 8'h00;
  logic       last_we = 1'b0;

  prg_mem_sequencer #(.PHASE_CYCLES(2)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .prg_ma(prg_ma), .prg_wd(prg_wd), .prg_rd(prg_rd),
    .prg_clock(prg_clock), .prg_we(prg_we), .cpu_reset_n(cpu_reset_n)
  );

  initial forever #5 clk_clk = ~clk_clk;

  assign prg_rd = mem[prg_ma];

  always @(negedge clk_clk) begin
    if (prg_clock) hi_cyc++;
    if (prg_we) we_cyc++;
  end

  always @(posedge prg_clock) begin
    pulses++;
    last_ma = prg_ma;
    last_wd = prg_wd;
    last_we = prg_we;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk_clk);
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk_clk);
      n++;
    end
    check("cmd_accept_timeout", 32'(n < 50), 32'd1);
    @(posedge clk_clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk_clk);
      lat++;
    end while (!rsp_valid && lat < 2000);
    check("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic take(output logic [7:0] d, output logic e);
    d = rsp_data;
    e = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk_clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    int lat, p0, h0, w0, n, seen;
    logic [7:0] d, d1;
    logic e;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h10] = 8'h3C;

    // Reset state
    repeat (2) @(negedge clk_clk);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_prg_ma", 32'(prg_ma), 0);
    check("rst_prg_wd", 32'(prg_wd), 0);
    check("rst_prg_clock", 32'(prg_clock), 0);
    check("rst_prg_we", 32'(prg_we), 0);
    check("rst_cpu_reset_n", 32'(cpu_reset_n), 0);
    reset_reset_n = 1'b1;
    #1 check("ready_before_edge", 32'(cmd_ready), 0);
    @(posedge clk_clk);
    #1 check("ready_after_edge", 32'(cmd_ready), 1);

    // Write 0x10 <- 0xA5
    p0 = pulses; h0 = hi_cyc; w0 = we_cyc;
    send(2'b00, 8'h10, 8'hA5);
    wait_rsp(lat);
    check("wr_latency", lat, 7);
    check("wr_we_cycles", we_cyc - w0, 6);
    check("wr_clk_hi_cycles", hi_cyc - h0, 2);
    check("wr_pulses", pulses - p0, 1);
    check("wr_pulse_ma", 32'(last_ma), 32'h10);
    check("wr_pulse_wd", 32'(last_wd), 32'hA5);
    check("wr_pulse_we", 32'(last_we), 1);
    take(d, e);
    check("wr_rsp_data", 32'(d), 32'hA5);
    check("wr_rsp_err", 32'(e), 0);
    #1 check("wr_we_after", 32'(prg_we), 0);

    // Read 0x10 -> 0x3C
    p0 = pulses; w0 = we_cyc;
    send(2'b01, 8'h10, 8'h00);
    wait_rsp(lat);
    check("rd_latency", lat, 7);
    check("rd_we_cycles", we_cyc - w0, 0);
    check("rd_pulses", pulses - p0, 1);
    take(d, e);
    check("rd_rsp_data", 32'(d), 32'h3C);
    check("rd_rsp_err", 32'(e), 0);

    // Burst read FE, FF, 00 with a 5-cycle stall on the second byte
    p0 = pulses;
    send(2'b10, 8'hFE, 8'h02);
    wait_rsp(lat);
    check("b0_latency", lat, 7);
    check("b0_ma", 32'(last_ma), 32'hFE);
    take(d, e);
    check("b0_data", 32'(d), 32'(8'hFE ^ 8'h5A));
    wait_rsp(lat);
    check("b1_spacing", lat, 7);
    check("b1_ma", 32'(last_ma), 32'hFF);
    d1 = rsp_data;
    n = pulses;
    repeat (5) @(negedge clk_clk);
    check("b1_stall_valid", 32'(rsp_valid), 1);
    check("b1_stall_data", 32'(rsp_data), 32'(d1));
    check("b1_stall_pulses", pulses, n);
    take(d, e);
    check("b1_data", 32'(d), 32'(8'hFF ^ 8'h5A));
    wait_rsp(lat);
    check("b2_spacing", lat, 7);
    check("b2_ma_wrap", 32'(last_ma), 32'h00);
    take(d, e);
    check("b2_data", 32'(d), 32'h5A);
    check("b2_err", 32'(e), 0);
    #1 check("burst_pulses", pulses - p0, 3);
    check("burst_done_ready", 32'(cmd_ready), 1);

    // Release CPU, then accesses are rejected
    send(2'b11, 8'h00, 8'h00);
    check("rel_cpu_reset_n", 32'(cpu_reset_n), 1);
    wait_rsp(lat);
    check("rel_latency", lat, 1);
    take(d, e);
    check("rel_rsp", {23'd0, e, d}, 32'h000);
    p0 = pulses; w0 = we_cyc;
    send(2'b00, 8'h20, 8'h11);
    wait_rsp(lat);
    take(d, e);
    check("rej_wr_rsp", {23'd0, e, d}, 32'h1FF);
    send(2'b10, 8'h00, 8'h05);
    wait_rsp(lat);
    check("rej_burst_latency", lat, 1);
    take(d, e);
    check("rej_burst_rsp", {23'd0, e, d}, 32'h1FF);
    @(negedge clk_clk);
    check("rej_burst_single", 32'(rsp_valid), 0);
    check("rej_pulses", pulses - p0, 0);
    check("rej_we_cycles", we_cyc - w0, 0);

    // Hold CPU again, writes work
    send(2'b11, 8'h00, 8'h01);
    check("hold_cpu_reset_n", 32'(cpu_reset_n), 0);
    wait_rsp(lat);
    take(d, e);
    check("hold_rsp", {23'd0, e, d}, 32'h001);
    send(2'b00, 8'h20, 8'h5A);
    wait_rsp(lat);
    take(d, e);
    check("wr2_rsp", {23'd0, e, d}, 32'h05A);

    // Reset during PULSE of a burst
    send(2'b10, 8'h40, 8'h03);
    n = 0;
    while (!prg_clock && n < 50) begin
      @(negedge clk_clk);
      n++;
    end
    check("pulse_seen", 32'(prg_clock), 1);
    p0 = pulses;
    reset_reset_n = 1'b0;
    #1;
    check("arst_prg_clock", 32'(prg_clock), 0);
    check("arst_cpu_reset_n", 32'(cpu_reset_n), 0);
    check("arst_rsp_valid", 32'(rsp_valid), 0);
    check("arst_cmd_ready", 32'(cmd_ready), 0);
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk_clk);
      if (rsp_valid) seen++;
    end
    check("arst_no_resp", seen, 0);
    check("arst_no_pulses", pulses - p0, 0);
    check("arst_ready_after", 32'(cmd_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prg_mem_sequencer.md
PRG_MEM_SEQUENCER -- requirements
Module: prg_mem_sequencer

Interface
REQ-001 SHALL have parameter PHASE_CYCLES, default 2, meaning clk_clk cycles per prg_clock phase (legal range 1..15).
REQ-002 SHALL have port clk_clk  input  1  the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-006 SHALL have port cmd_op  input  2  00 write, 01 read, 10 burst read, 11 CPU reset control.
REQ-007 SHALL have port cmd_addr  input  8  start address.
REQ-008 SHALL have port cmd_data  input  8  write data (op 00), burst length minus 1 (op 10), bit0 = hold CPU in reset (op 11).
REQ-009 SHALL have port rsp_valid  output  1  response byte available.
REQ-010 SHALL have port rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-011 SHALL have port rsp_data  output  8  response byte.
REQ-012 SHALL have port rsp_err  output  1  response flags a rejected command.
REQ-013 SHALL have ports prg_ma, prg_wd  output  8 each  program-memory address and write data.
REQ-014 SHALL have port prg_rd  input  8  program-memory read data.
REQ-015 SHALL have ports prg_clock, prg_we  output  1 each  memory clock pulse and write enable.
REQ-016 SHALL have port cpu_reset_n  output  1  target CPU reset, active-low.

Function
REQ-017 SHALL implement states IDLE, SETUP, PULSE, HOLD, RESP; cmd_ready SHALL be high only in IDLE.
REQ-018 On acceptance of op 00/01/10 with cpu_reset_n low: latch addr, data, op; set burst count = cmd_data+1 for op 10, else 1; go to SETUP.
REQ-019 SETUP: prg_ma, prg_wd, prg_we (1 only for op 00) stable, prg_clock low, PHASE_CYCLES cycles, then PULSE.
REQ-020 PULSE: prg_clock high, prg_ma/prg_wd/prg_we unchanged, PHASE_CYCLES cycles, then HOLD.
REQ-021 HOLD: prg_clock low, prg_ma/prg_wd/prg_we unchanged, PHASE_CYCLES cycles; on the last HOLD cycle capture prg_rd into rsp_data (reads) or latched write data (writes); then RESP; prg_we drops to 0 on leaving HOLD.
REQ-022 RESP: rsp_valid high, rsp_err 0, held until handshake; then if remaining count > 1: decrement, address +1 modulo 256 (8'hFF wraps to 8'h00), go to SETUP; else IDLE.
REQ-023 Exactly one prg_clock pulse and one response SHALL occur per byte; a burst of cmd_data = 8'hFF yields 256 pulses and 256 responses.
REQ-024 Latency from acceptance to rsp_valid SHALL be 3*PHASE_CYCLES+1 cycles; byte-to-byte spacing in a burst with rsp_ready tied high SHALL be 3*PHASE_CYCLES+1 cycles.
REQ-025 Op 00/01/10 accepted while cpu_reset_n high SHALL generate no prg_clock pulse and no prg_we and SHALL go directly to RESP with rsp_data 8'hFF, rsp_err 1 (single response, even for op 10).
REQ-026 Op 11 SHALL set cpu_reset_n = ~cmd_data[0] on the cycle after acceptance, then go to RESP with rsp_data = {7'b0, cmd_data[0]}, rsp_err 0.
REQ-027 rsp_valid low with rsp_ready high SHALL have no effect; rsp_data/rsp_err SHALL stay stable while rsp_valid is high and rsp_ready is low.
REQ-028 prg_clock SHALL never be high outside PULSE; prg_ma/prg_wd SHALL change only in IDLE or on entry to SETUP.

Reset
REQ-029 While reset_reset_n low, immediately and asynchronously: state IDLE, cmd_ready 0, rsp_valid 0, rsp_err 0, rsp_data 0, prg_ma 0, prg_wd 0, prg_clock 0, prg_we 0, cpu_reset_n 0 (CPU held).
REQ-030 cmd_ready SHALL rise on the first clock edge after reset_reset_n deasserts.
REQ-031 Reset mid-access or mid-burst SHALL abort without completing the pulse; no response for the aborted byte; no resume after reset.

Verification
REQ-032 PHASE_CYCLES=2, write addr 8'h10 data 8'hA5 -> prg_we=1 and prg_ma=8'h10, prg_wd=8'hA5 for 6 cycles, one prg_clock pulse 2 cycles wide, rsp 8'hA5 err 0 at cycle 7.
REQ-033 Read addr 8'h10 with memory model returning 8'h3C -> prg_we stays 0, rsp_data 8'h3C.
REQ-034 Burst read addr 8'hFE, cmd_data 8'h02 -> addresses FE, FF, 00; three pulses, three responses; rsp_ready held low 5 cycles on second byte stalls without extra pulses.
REQ-035 Op 11 data 0 (release CPU), then write -> rsp_err 1, rsp_data 8'hFF, zero prg_clock pulses; op 11 data 1 -> cpu_reset_n 0, writes succeed again.
REQ-036 Assert reset_reset_n low during PULSE of a burst -> prg_clock 0 same cycle, cpu_reset_n 0, rsp_valid 0; after release cmd_ready 1, no residual responses.
